// File: rtl/timer_seq_ctrl.sv
// Sequencing controller for a countdown timer: SET/RUN/PAUSE/EXPIRED flow, digit gating and alarm.
// Optional SET inactivity timeout is compiled in when TIMER_SEQ_SET_TIMEOUT_EN is defined.
module timer_seq_ctrl #(
    parameter int unsigned ALARM_SECS  = 10,
    parameter int unsigned SET_TIMEOUT = 30
) (
    input  logic       clk_1Hz,
    input  logic       resetn,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic [4:0] tmr_hour,
    input  logic [5:0] tmr_min,
    input  logic [5:0] tmr_sec,
    output logic       timer_mode,
    output logic       timer_start_stop,
    output logic       timer_hour_in,
    output logic       timer_min_in,
    output logic       timer_sec_in,
    output logic       alarm_out,
    output logic [2:0] state_code
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET     = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSE   = 3'd3,
        S_EXPIRED = 3'd4
    } state_t;

    localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECS - 1);

    state_t     state_q, state_d;
    logic [5:0] alarm_cnt_q, alarm_cnt_d;
    logic       alarm_q, alarm_d;
    logic       mode_q, mode_d;
    logic       run_q, run_d;
    logic [2:0] digit_q, digit_d;
    logic       tmr_zero;

`ifdef TIMER_SEQ_SET_TIMEOUT_EN
    localparam logic [5:0] TIMEOUT_LIM = 6'(SET_TIMEOUT);
    logic [5:0] idle_cnt_q, idle_cnt_d;
`else
    localparam logic [5:0] UNUSED_SET_TIMEOUT = 6'(SET_TIMEOUT);
`endif

    assign tmr_zero = (tmr_hour == 5'd0) && (tmr_min == 6'd0) && (tmr_sec == 6'd0);

    always_comb begin
        state_d     = state_q;
        alarm_cnt_d = alarm_cnt_q;
        digit_d     = 3'b000;
`ifdef TIMER_SEQ_SET_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (btn_mode) begin
                    state_d = S_SET;
`ifdef TIMER_SEQ_SET_TIMEOUT_EN
                    idle_cnt_d = 6'd0;
`endif
                end
            end
            S_SET: begin
                if (btn_mode) begin
                    state_d = S_IDLE;
                end else if (btn_start && !tmr_zero) begin
                    state_d = S_RUN;
                end else begin
                    // A rejected start still outranks the digit buttons this cycle.
                    digit_d = btn_start ? 3'b000 : {btn_hour, btn_min, btn_sec};
`ifdef TIMER_SEQ_SET_TIMEOUT_EN
                    if (btn_hour || btn_min || btn_sec) begin
                        idle_cnt_d = 6'd0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 6'd1;
                        if (idle_cnt_d == TIMEOUT_LIM) begin
                            state_d = S_IDLE;
                        end
                    end
`endif
                end
            end
            S_RUN: begin
                if (btn_mode) begin
                    state_d = S_IDLE;
                end else if (btn_start) begin
                    state_d = S_PAUSE;
                end else if (tmr_zero) begin
                    state_d     = S_EXPIRED;
                    alarm_cnt_d = 6'd0;
                end
            end
            S_PAUSE: begin
                if (btn_mode) begin
                    state_d = S_IDLE;
                end else if (btn_start) begin
                    state_d = S_RUN;
                end
            end
            S_EXPIRED: begin
                if (btn_mode || btn_start || (alarm_cnt_q == ALARM_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with state_code.
        mode_d  = (state_d == S_SET) || (state_d == S_RUN) || (state_d == S_PAUSE);
        run_d   = (state_d == S_RUN);
        alarm_d = (state_d == S_EXPIRED) && ((state_q == S_EXPIRED) ? !alarm_q : 1'b1);
    end

    always_ff @(posedge clk_1Hz) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            alarm_cnt_q <= 6'd0;
            alarm_q     <= 1'b0;
            mode_q      <= 1'b0;
            run_q       <= 1'b0;
            digit_q     <= 3'b000;
`ifdef TIMER_SEQ_SET_TIMEOUT_EN
            idle_cnt_q  <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            alarm_cnt_q <= alarm_cnt_d;
            alarm_q     <= alarm_d;
            mode_q      <= mode_d;
            run_q       <= run_d;
            digit_q     <= digit_d;
`ifdef TIMER_SEQ_SET_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign timer_mode       = mode_q;
    assign timer_start_stop = run_q;
    assign timer_hour_in    = digit_q[2];
    assign timer_min_in     = digit_q[1];
    assign timer_sec_in     = digit_q[0];
    assign alarm_out        = alarm_q;
    assign state_code       = state_q;

endmodule

// File: doc/timer_seq_ctrl.md
TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 Parameter ALARM_SECS, default 10, sets the alarm duration in clk_1Hz cycles (range 1..63).
REQ-002 Parameter SET_TIMEOUT, default 30, sets the idle limit in SET in cycles (range 1..63); used only when TIMER_SEQ_SET_TIMEOUT_EN is defined.
REQ-003 clk_1Hz  input  1  clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 btn_mode  input  1  debounced single-cycle pulse; mode toggle or cancel.
REQ-006 btn_start  input  1  debounced single-cycle pulse; start, pause or resume.
REQ-007 btn_hour, btn_min, btn_sec  input  1 each  debounced single-cycle digit-increment pulses.
REQ-008 tmr_hour  input  5, tmr_min  input  6, tmr_sec  input  6  current countdown value fed back from the timer.
REQ-009 timer_mode  output  1  level; drives the timer mode input.
REQ-010 timer_start_stop  output  1  level; drives the timer start/stop input.
REQ-011 timer_hour_in, timer_min_in, timer_sec_in  output  1 each  gated digit pulses to the timer.
REQ-012 alarm_out  output  1  buzzer/LED drive.
REQ-013 state_code  output  3  current state: IDLE=0, SET=1, RUN=2, PAUSE=3, EXPIRED=4.

Function
REQ-014 All outputs shall be registered; a response to an input sampled at edge N shall be visible after edge N.
REQ-015 IDLE: timer_mode=0, timer_start_stop=0, alarm_out=0; btn_mode shall move to SET; all other inputs shall be ignored.
REQ-016 SET: timer_mode=1, timer_start_stop=0; each digit button shall produce exactly one one-cycle pulse on the matching timer_*_in output; btn_mode shall move to IDLE.
REQ-017 SET: btn_start shall move to RUN only if {tmr_hour,tmr_min,tmr_sec} is nonzero; with an all-zero value it shall be ignored and the state shall remain SET.
REQ-018 Outside SET, all timer_*_in outputs shall be 0 and digit buttons shall be ignored.
REQ-019 RUN: timer_mode=1, timer_start_stop=1; btn_start shall move to PAUSE; btn_mode shall move to IDLE.
REQ-020 RUN: if btn_mode and btn_start are both low and tmr_hour, tmr_min and tmr_sec are all zero, the state shall move to EXPIRED.
REQ-021 PAUSE: timer_mode=1, timer_start_stop=0; btn_start shall move to RUN; btn_mode shall move to IDLE; no expiry check.
REQ-022 EXPIRED: timer_mode=0, timer_start_stop=0; alarm_out shall be 1 in the first EXPIRED cycle and toggle every cycle after that.
REQ-023 EXPIRED: a 6-bit alarm counter shall clear on entry and increment each cycle; the state shall move to IDLE after ALARM_SECS cycles, or on btn_start or btn_mode, whichever comes first.
REQ-024 Simultaneous pulses: btn_mode shall beat btn_start, and btn_start shall beat the digit buttons; a losing pulse shall be dropped, not queued.
REQ-025 Simultaneous digit buttons in SET shall be forwarded in the same cycle, independently.
REQ-026 Undefined state_code values (5..7) shall recover to IDLE on the next edge.

Reset
REQ-027 While resetn=0 at a rising edge: state IDLE, all outputs 0, alarm and timeout counters 0.
REQ-028 A reset asserted mid-RUN or mid-EXPIRED shall take effect at that edge, silence alarm_out immediately and drop any pulse sampled in the same cycle.

Configuration
REQ-029 Macro TIMER_SEQ_SET_TIMEOUT_EN defined: a 6-bit inactivity counter shall clear on SET entry and on any digit button, increment otherwise in SET, and force IDLE when it reaches SET_TIMEOUT.
REQ-030 Macro TIMER_SEQ_SET_TIMEOUT_EN undefined: no inactivity counter shall exist, and SET shall be left only by btn_mode or a valid btn_start.

Verification
REQ-031 Reset, then btn_mode pulse -> state_code 0 then 1 on the next edge; timer_mode=1.
REQ-032 SET with tmr value 0:00:00, btn_start -> state remains 1; timer_start_stop stays 0.
REQ-033 SET, btn_min x3 -> exactly three one-cycle timer_min_in pulses; with tmr 0:00:02, btn_start -> RUN; tmr reaches 0:00:00 -> EXPIRED; alarm_out 1,0,1,... for 10 cycles, then IDLE.
REQ-034 RUN with btn_mode and btn_start in the same cycle -> IDLE; timer_mode=0, no PAUSE visited.
REQ-035 EXPIRED, resetn low at cycle 3 -> alarm_out=0 and state_code=0 after that edge.
REQ-036 TIMER_SEQ_SET_TIMEOUT_EN defined, SET_TIMEOUT=5, no buttons -> IDLE after 5 cycles; undefined -> still SET after 100 cycles.
